// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the decode-stage ALU control: select codes, main-control
// classes, R-type funct values, mul/div operation codes and sequencer states.
package alu_ctrl_pkg;

  localparam logic [3:0] SEL_AND     = 4'b0000;
  localparam logic [3:0] SEL_SUB     = 4'b0001;
  localparam logic [3:0] SEL_OR      = 4'b0010;
  localparam logic [3:0] SEL_ADD     = 4'b0011;
  localparam logic [3:0] SEL_LUI     = 4'b0100;
  localparam logic [3:0] SEL_NOR     = 4'b0101;
  localparam logic [3:0] SEL_SLT     = 4'b0110;
  localparam logic [3:0] SEL_SLL     = 4'b0111;
  localparam logic [3:0] SEL_SRL     = 4'b1000;
  localparam logic [3:0] SEL_DEFAULT = 4'b1001;

  localparam logic [2:0] AOP_MEM   = 3'b000;
  localparam logic [2:0] AOP_LUI   = 3'b001;
  localparam logic [2:0] AOP_ORI   = 3'b010;
  localparam logic [2:0] AOP_ANDI  = 3'b011;
  localparam logic [2:0] AOP_ADDI  = 3'b100;
  localparam logic [2:0] AOP_BR    = 3'b101;
  localparam logic [2:0] AOP_RTYPE = 3'b111;

  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } md_state_t;

endpackage

// File: rtl/alu_decode.sv
// Combinational decode of {alu_op, funct} into ALU select plus mul/div and
// HI/LO-read classification; independent of instruction valid.
module alu_decode
  import alu_ctrl_pkg::*;
#(
  parameter int ALU_OP_W  = 3,
  parameter int FUNCT_W   = 6,
  parameter int ALU_SEL_W = 4
) (
  input  logic [ALU_OP_W-1:0]  alu_op_i,
  input  logic [FUNCT_W-1:0]   funct_i,
  output logic [ALU_SEL_W-1:0] alu_operation_o,
  output logic                 illegal_o,
  output logic                 is_md_o,
  output logic                 is_mfhilo_o,
  output logic [1:0]           md_op_o
);

  logic [3:0] sel;

  always_comb begin
    sel         = SEL_DEFAULT;
    illegal_o   = 1'b0;
    is_md_o     = 1'b0;
    is_mfhilo_o = 1'b0;
    md_op_o     = MD_MULT;
    case (alu_op_i)
      ALU_OP_W'(AOP_RTYPE): begin
        case (funct_i)
          FUNCT_W'(FN_ADD): sel = SEL_ADD;
          FUNCT_W'(FN_SUB): sel = SEL_SUB;
          FUNCT_W'(FN_AND): sel = SEL_AND;
          FUNCT_W'(FN_OR):  sel = SEL_OR;
          FUNCT_W'(FN_NOR): sel = SEL_NOR;
          FUNCT_W'(FN_SLT): sel = SEL_SLT;
          FUNCT_W'(FN_SLL): sel = SEL_SLL;
          FUNCT_W'(FN_SRL): sel = SEL_SRL;
          FUNCT_W'(FN_MULT):  begin sel = SEL_ADD; is_md_o = 1'b1; md_op_o = MD_MULT;  end
          FUNCT_W'(FN_MULTU): begin sel = SEL_ADD; is_md_o = 1'b1; md_op_o = MD_MULTU; end
          FUNCT_W'(FN_DIV):   begin sel = SEL_ADD; is_md_o = 1'b1; md_op_o = MD_DIV;   end
          FUNCT_W'(FN_DIVU):  begin sel = SEL_ADD; is_md_o = 1'b1; md_op_o = MD_DIVU;  end
          FUNCT_W'(FN_MFHI), FUNCT_W'(FN_MFLO): begin
            sel         = SEL_ADD;
            is_mfhilo_o = 1'b1;
          end
          default: illegal_o = 1'b1;
        endcase
      end
      ALU_OP_W'(AOP_ADDI): sel = SEL_ADD;
      ALU_OP_W'(AOP_MEM):  sel = SEL_ADD;
      ALU_OP_W'(AOP_BR):   sel = SEL_SUB;
      ALU_OP_W'(AOP_ANDI): sel = SEL_AND;
      ALU_OP_W'(AOP_ORI):  sel = SEL_OR;
      ALU_OP_W'(AOP_LUI):  sel = SEL_LUI;
      default:             illegal_o = 1'b1;
    endcase
    alu_operation_o = ALU_SEL_W'(sel);
  end

endmodule

// File: rtl/alu_control_seq.sv
// Decode-stage ALU control with a launch/countdown/writeback sequencer for the
// iterative multiply/divide unit and the HI/LO dependency interlock.
module alu_control_seq
  import alu_ctrl_pkg::*;
#(
  parameter int ALU_OP_W   = 3,
  parameter int FUNCT_W    = 6,
  parameter int ALU_SEL_W  = 4,
  parameter int MUL_CYCLES = 32,
  parameter int DIV_CYCLES = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid_i,
  input  logic [ALU_OP_W-1:0]  alu_op_i,
  input  logic [FUNCT_W-1:0]   alu_function_i,
  output logic [ALU_SEL_W-1:0] alu_operation_o,
  output logic                 illegal_o,
  output logic                 stall_o,
  output logic                 md_start_o,
  output logic [1:0]           md_op_o,
  output logic                 md_busy_o,
  output logic                 md_done_o
);

  localparam int MAX_LAT = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_LAT);

  logic             dec_illegal;
  logic             dec_is_md;
  logic             dec_is_mfhilo;
  logic [1:0]       dec_md_op;
  logic             accept;
  logic [CNT_W-1:0] lat_m1;
  logic [CNT_W-1:0] cnt;
  md_state_t        state;

  alu_decode #(
    .ALU_OP_W  (ALU_OP_W),
    .FUNCT_W   (FUNCT_W),
    .ALU_SEL_W (ALU_SEL_W)
  ) u_decode (
    .alu_op_i        (alu_op_i),
    .funct_i         (alu_function_i),
    .alu_operation_o (alu_operation_o),
    .illegal_o       (dec_illegal),
    .is_md_o         (dec_is_md),
    .is_mfhilo_o     (dec_is_mfhilo),
    .md_op_o         (dec_md_op)
  );

  assign illegal_o  = valid_i & dec_illegal;
  assign accept     = valid_i & dec_is_md & (state == ST_IDLE);
  assign md_start_o = accept;
  assign md_busy_o  = (state != ST_IDLE);
  assign md_done_o  = (state == ST_DONE);
  // DONE still stalls HI/LO consumers: the result lands at the end of that cycle.
  assign stall_o    = valid_i & (state != ST_IDLE) & (dec_is_md | dec_is_mfhilo);

  assign lat_m1 = (dec_md_op == MD_DIV || dec_md_op == MD_DIVU) ?
                  CNT_W'(DIV_CYCLES - 1) : CNT_W'(MUL_CYCLES - 1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      md_op_o <= MD_MULT;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            md_op_o <= dec_md_op;
            cnt     <= lat_m1;
            state   <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (cnt == '0) state <= ST_DONE;
          else           cnt   <= cnt - 1'b1;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_control_seq.sv
// Directed bench for alu_control_seq: decode sweep, mul/div sequencing,
// HI/LO interlock, back-to-back launch and mid-operation reset.
module tb_alu_control_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       valid_i;
  logic [2:0] alu_op_i;
  logic [5:0] alu_function_i;
  logic [3:0] alu_operation_o;
  logic       illegal_o, stall_o, md_start_o, md_busy_o, md_done_o;
  logic [1:0] md_op_o;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_control_seq #(
    .ALU_OP_W   (3),
    .FUNCT_W    (6),
    .ALU_SEL_W  (4),
    .MUL_CYCLES (32),
    .DIV_CYCLES (32)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .valid_i         (valid_i),
    .alu_op_i        (alu_op_i),
    .alu_function_i  (alu_function_i),
    .alu_operation_o (alu_operation_o),
    .illegal_o       (illegal_o),
    .stall_o         (stall_o),
    .md_start_o      (md_start_o),
    .md_op_o         (md_op_o),
    .md_busy_o       (md_busy_o),
    .md_done_o       (md_done_o)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_in(input logic v, input logic [2:0] op, input logic [5:0] fn);
    valid_i        = v;
    alu_op_i       = op;
    alu_function_i = fn;
    #1;
  endtask

  task automatic dec_chk(input string tag, input logic v, input logic [2:0] op,
                         input logic [5:0] fn, input int sel, input int ill);
    set_in(v, op, fn);
    chk({tag, "_sel"}, int'(alu_operation_o), sel);
    chk({tag, "_ill"}, int'(illegal_o), ill);
    chk({tag, "_start"}, int'(md_start_o), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt, done_cnt, done_at, start_cnt;

    reset = 1'b0;
    set_in(1'b0, 3'b000, 6'b000000);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", int'(md_busy_o), 0);
    chk("rst_done", int'(md_done_o), 0);
    chk("rst_start", int'(md_start_o), 0);
    chk("rst_stall", int'(stall_o), 0);
    chk("rst_mdop", int'(md_op_o), 0);
    reset = 1'b1;
    tick();

    // Decode sweep; mul/div encodings with valid low so the FSM stays idle.
    dec_chk("r_add",  1, 3'b111, 6'b100000, 4'b0011, 0);
    dec_chk("r_sub",  1, 3'b111, 6'b100010, 4'b0001, 0);
    dec_chk("r_and",  1, 3'b111, 6'b100100, 4'b0000, 0);
    dec_chk("r_or",   1, 3'b111, 6'b100101, 4'b0010, 0);
    dec_chk("r_nor",  1, 3'b111, 6'b100111, 4'b0101, 0);
    dec_chk("r_slt",  1, 3'b111, 6'b101010, 4'b0110, 0);
    dec_chk("r_sll",  1, 3'b111, 6'b000000, 4'b0111, 0);
    dec_chk("r_srl",  1, 3'b111, 6'b000010, 4'b1000, 0);
    dec_chk("r_mfhi", 1, 3'b111, 6'b010000, 4'b0011, 0);
    dec_chk("r_mflo", 1, 3'b111, 6'b010010, 4'b0011, 0);
    chk("mflo_idle_stall", int'(stall_o), 0);
    dec_chk("r_mult",  0, 3'b111, 6'b011000, 4'b0011, 0);
    dec_chk("r_multu", 0, 3'b111, 6'b011001, 4'b0011, 0);
    dec_chk("r_div",   0, 3'b111, 6'b011010, 4'b0011, 0);
    dec_chk("r_divu",  0, 3'b111, 6'b011011, 4'b0011, 0);
    chk("v0_mult_stall", int'(stall_o), 0);
    dec_chk("r_bad",  1, 3'b111, 6'b111111, 4'b1001, 1);
    dec_chk("i_addi", 1, 3'b100, 6'b101010, 4'b0011, 0);
    dec_chk("i_mem",  1, 3'b000, 6'b111111, 4'b0011, 0);
    dec_chk("i_br",   1, 3'b101, 6'b000000, 4'b0001, 0);
    dec_chk("i_andi", 1, 3'b011, 6'b100101, 4'b0000, 0);
    dec_chk("i_ori",  1, 3'b010, 6'b100100, 4'b0010, 0);
    dec_chk("i_lui",  1, 3'b001, 6'b100010, 4'b0100, 0);
    dec_chk("op110",  1, 3'b110, 6'b100000, 4'b1001, 1);
    dec_chk("op110_v0", 0, 3'b110, 6'b100000, 4'b1001, 0);
    set_in(1'b0, 3'b000, 6'b000000);
    tick();
    chk("idle_after_sweep", int'(md_busy_o), 0);

    // MULT latency: busy t+1..t+33, done only at t+33.
    set_in(1'b1, 3'b111, 6'b011000);
    chk("mult_start_t", int'(md_start_o), 1);
    chk("mult_stall_t", int'(stall_o), 0);
    tick();
    set_in(1'b0, 3'b000, 6'b000000);
    busy_cnt = 0; done_cnt = 0; done_at = 0; start_cnt = 0;
    for (int k = 1; k <= 34; k++) begin
      if (md_busy_o)  busy_cnt++;
      if (md_start_o) start_cnt++;
      if (md_done_o) begin done_cnt++; done_at = k; end
      tick();
    end
    chk("mult_busy_cycles", busy_cnt, 33);
    chk("mult_done_count", done_cnt, 1);
    chk("mult_done_at", done_at, 33);
    chk("mult_extra_start", start_cnt, 0);
    chk("mult_mdop", int'(md_op_o), 0);

    // DIVU then dependent MFLO: stalled t+1..t+33, released t+34.
    set_in(1'b1, 3'b111, 6'b011011);
    chk("divu_start", int'(md_start_o), 1);
    tick();
    set_in(1'b1, 3'b111, 6'b010010);
    chk("divu_mdop", int'(md_op_o), 3);
    for (int k = 1; k <= 34; k++) begin
      chk($sformatf("mflo_stall_%0d", k), int'(stall_o), (k <= 33) ? 1 : 0);
      if (k < 34) tick();
    end
    chk("mflo_release_busy", int'(md_busy_o), 0);
    set_in(1'b0, 3'b000, 6'b000000);
    tick();

    // DIVU then independent ADD: no stall.
    set_in(1'b1, 3'b111, 6'b011011);
    chk("divu2_start", int'(md_start_o), 1);
    tick();
    set_in(1'b1, 3'b111, 6'b100000);
    chk("add_nostall", int'(stall_o), 0);
    chk("add_busy", int'(md_busy_o), 1);
    set_in(1'b0, 3'b000, 6'b000000);
    repeat (33) tick();
    chk("divu2_idle", int'(md_busy_o), 0);

    // DIV then MULT back-to-back: MULT held through DONE, launched at t+34.
    set_in(1'b1, 3'b111, 6'b011010);
    chk("div_start", int'(md_start_o), 1);
    tick();
    set_in(1'b1, 3'b111, 6'b011000);
    start_cnt = 0;
    for (int k = 1; k <= 34; k++) begin
      chk($sformatf("b2b_stall_%0d", k), int'(stall_o), (k <= 33) ? 1 : 0);
      if (md_start_o) start_cnt++;
      if (k == 34) chk("b2b_start_t34", int'(md_start_o), 1);
      tick();
    end
    chk("b2b_start_count", start_cnt, 1);
    set_in(1'b0, 3'b000, 6'b000000);
    chk("b2b_mdop", int'(md_op_o), 0);
    chk("b2b_busy", int'(md_busy_o), 1);
    repeat (33) tick();
    chk("b2b_idle", int'(md_busy_o), 0);

    // Reset mid-BUSY (cnt=10) on a DIV: immediate idle, no late done.
    set_in(1'b1, 3'b111, 6'b011010);
    chk("rdiv_start", int'(md_start_o), 1);
    tick();
    set_in(1'b0, 3'b000, 6'b000000);
    repeat (21) tick();
    chk("rdiv_mdop_pre", int'(md_op_o), 2);
    chk("rdiv_busy_pre", int'(md_busy_o), 1);
    reset = 1'b0;
    #1;
    chk("rdiv_busy", int'(md_busy_o), 0);
    chk("rdiv_done", int'(md_done_o), 0);
    chk("rdiv_mdop", int'(md_op_o), 0);
    chk("rdiv_stall", int'(stall_o), 0);
    #1;
    reset = 1'b1;
    done_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (md_done_o || md_busy_o) done_cnt++;
    end
    chk("rdiv_no_done", done_cnt, 0);

    set_in(1'b1, 3'b111, 6'b011000);
    chk("post_rst_start", int'(md_start_o), 1);
    tick();
    set_in(1'b0, 3'b000, 6'b000000);
    busy_cnt = 0; done_at = 0;
    for (int k = 1; k <= 34; k++) begin
      if (md_busy_o) busy_cnt++;
      if (md_done_o) done_at = k;
      tick();
    end
    chk("post_rst_busy", busy_cnt, 33);
    chk("post_rst_done_at", done_at, 33);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
